// File: rtl/axil_reg_pkg.sv
// Shared constants for the AES256 AXI4-Lite register slave: response codes and
// register-index addressing.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offset bits below this are ignored; the word index starts here.
  localparam int REG_IDX_LSB = 2;

  function automatic int reg_idx_width(input int addr_width);
    return addr_width - REG_IDX_LSB;
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file for the AES256 core; AW+W handshake -> BVALID two cycles later, AR -> RVALID one cycle later.
// Full AW/W slots stall their READY until committed; a held B response blocks further commits, a held R response blocks AR.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int IDX_W = reg_idx_width(C_S_AXI_ADDR_WIDTH);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int LANES = C_S_AXI_DATA_WIDTH / 8;

  logic             aw_full, w_full;
  logic [IDX_W-1:0] aw_idx;
  logic [DW-1:0]    w_data;
  logic [LANES-1:0] w_strb;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic             aw_in_range, ar_in_range;
  logic [IDX_W-1:0] ar_idx;
  logic [NUM_REGS-1:0] wr_sel;

  logic             aw_full_nxt, w_full_nxt, bvalid_nxt;
  logic [1:0]       bresp_nxt;
  logic             rvalid_nxt;
  logic [DW-1:0]    rdata_nxt, rd_mux;
  logic [1:0]       rresp_nxt;

  logic unused;
  assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[REG_IDX_LSB-1:0], S_AXI_ARADDR[REG_IDX_LSB-1:0]};

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);

  assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:REG_IDX_LSB];
  assign aw_in_range = int'(aw_idx) < NUM_REGS;
  assign ar_in_range = int'(ar_idx) < NUM_REGS;

  // Write path: slot flags and B channel next state.
  always_comb begin
    aw_full_nxt = aw_full;
    w_full_nxt  = w_full;
    bvalid_nxt  = S_AXI_BVALID;
    bresp_nxt   = S_AXI_BRESP;
    if (S_AXI_BVALID && S_AXI_BREADY) bvalid_nxt = 1'b0;
    if (aw_hs) aw_full_nxt = 1'b1;
    if (w_hs)  w_full_nxt  = 1'b1;
    if (commit) begin
      aw_full_nxt = 1'b0;
      w_full_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
      bresp_nxt   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      aw_full       <= aw_full_nxt;
      w_full        <= w_full_nxt;
      S_AXI_AWREADY <= !aw_full_nxt;
      S_AXI_WREADY  <= !w_full_nxt;
      S_AXI_BVALID  <= bvalid_nxt;
      S_AXI_BRESP   <= bresp_nxt;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:REG_IDX_LSB];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // Register file: one flop byte per lane, merged under the stored strobe.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign wr_sel[r] = commit && (int'(aw_idx) == r);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [7:0] lane_q;
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
          lane_q <= '0;
        else if (wr_sel[r] && w_strb[k])
          lane_q <= w_data[8*k +: 8];
      end
      assign reg_q[r*DW + 8*k +: 8] = lane_q;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) reg_wr_pulse <= '0;
    else                reg_wr_pulse <= wr_sel;
  end

  // Read path: mux samples pre-commit contents, so a same-edge write is not visible.
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (int'(ar_idx) == r) rd_mux = reg_q[r*DW +: DW];
  end

  always_comb begin
    rvalid_nxt = S_AXI_RVALID;
    rdata_nxt  = S_AXI_RDATA;
    rresp_nxt  = S_AXI_RRESP;
    if (S_AXI_RVALID && S_AXI_RREADY) rvalid_nxt = 1'b0;
    if (ar_hs) begin
      rvalid_nxt = 1'b1;
      rdata_nxt  = ar_in_range ? rd_mux : '0;
      rresp_nxt  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
    end else begin
      S_AXI_RVALID  <= rvalid_nxt;
      S_AXI_RDATA   <= rdata_nxt;
      S_AXI_RRESP   <= rresp_nxt;
      S_AXI_ARREADY <= !rvalid_nxt;
    end
  end

  a_b_hold: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    S_AXI_BVALID && !S_AXI_BREADY |=> S_AXI_BVALID && $stable(S_AXI_BRESP));
  a_r_hold: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    S_AXI_RVALID && !S_AXI_RREADY |=> S_AXI_RVALID && $stable(S_AXI_RDATA) && $stable(S_AXI_RRESP));
  a_pulse_onehot: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    $onehot0(reg_wr_pulse));

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed and randomized bench for axil_reg_slave, checked against a word-array model of the register file.
module tb_axil_reg_slave;

  localparam int NREG = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [4:0]    awaddr = '0;
  logic [2:0]    awprot = 3'b111;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [4:0]    araddr = '0;
  logic [2:0]    arprot = 3'b101;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [127:0]  reg_q;
  logic [3:0]    reg_wr_pulse;

  logic [31:0]   mdl [NREG];
  int            n_chk = 0;
  int            n_err = 0;

  axil_reg_slave dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [127:0] mdl_flat();
    logic [127:0] f;
    for (int i = 0; i < NREG; i++) f[i*32 +: 32] = mdl[i];
    return f;
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ready"}, {awready, wready, arready}, 3'b000);
    chk({pfx, "_valid"}, {bvalid, rvalid}, 2'b00);
    chk({pfx, "_resp"},  {bresp, rresp}, 4'b0000);
    chk({pfx, "_rdata"}, rdata, 32'h0);
    chk({pfx, "_regq"},  reg_q, 128'h0);
    chk({pfx, "_pulse"}, reg_wr_pulse, 4'b0000);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdly);
    int idx, n, lat;
    logic aw_hs, w_hs, aw_done, w_done;
    logic [3:0] exp_pulse;
    logic [1:0] exp_resp;
    idx = int'(addr[4:2]);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step(); n++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    lat = 0;
    while (!bvalid && lat < 20) begin step(); lat++; end
    chk("wr_lat", lat, 1);
    if (idx < NREG) begin
      mdl[idx]  = (mdl[idx] & ~strb_mask(strb)) | (data & strb_mask(strb));
      exp_pulse = 4'(1 << idx);
      exp_resp  = 2'b00;
    end else begin
      exp_pulse = 4'b0000;
      exp_resp  = 2'b10;
    end
    chk("wr_bresp", bresp, exp_resp);
    chk("wr_regq", reg_q, mdl_flat());
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    for (int i = 0; i < bdly; i++) begin
      step();
      chk("wr_bhold", {bvalid, bresp}, {1'b1, exp_resp});
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("wr_bdone", bvalid, 1'b0);
    chk("wr_pulse_clear", reg_wr_pulse, 4'b0000);
  endtask

  task automatic axi_read(input logic [4:0] addr, input int rdly);
    int idx, n;
    logic hs;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    idx = int'(addr[4:2]);
    if (idx < NREG) begin exp_d = mdl[idx]; exp_r = 2'b00; end
    else            begin exp_d = 32'h0;    exp_r = 2'b10; end
    araddr = addr; arvalid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      hs = arready;
      step(); n++;
    end
    arvalid = 1'b0;
    chk("rd_accept", hs, 1'b1);
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_arready_low", arready, 1'b0);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("rd_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, exp_r, exp_d});
    end
    chk("rd_rdata", rdata, exp_d);
    chk("rd_rresp", rresp, exp_r);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rd_done", rvalid, 1'b0);
  endtask

  initial begin
    logic [127:0] snap;
    logic [31:0]  prev;
    logic [2:0]   word;
    logic [4:0]   a;

    for (int i = 0; i < NREG; i++) mdl[i] = '0;

    // Reset state and READY rise on the first edge after release
    step(); step();
    chk_all_zero("rst");
    aresetn = 1'b1;
    chk("rst_ready_pre_edge", {awready, wready, arready}, 3'b000);
    step();
    chk("rst_ready_post_edge", {awready, wready, arready}, 3'b111);

    // Basic writes to every register, then readback
    for (int i = 0; i < NREG; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0);
    chk("basic_regq", reg_q, 128'h00000004_00000003_00000002_00000001);
    for (int i = 0; i < NREG; i++) axi_read(5'(i * 4), 0);

    // Byte-strobe merge
    axi_write(5'h00, 32'hAABBCCDD, 4'hF, 0);
    axi_write(5'h00, 32'h11223344, 4'b0101, 0);
    chk("strb_merge", reg_q[31:0], 32'hAA22CC44);
    axi_read(5'h00, 0);

    // W leads AW by three cycles; a second out-of-range write waits while B is held
    bready = 1'b0;
    wdata = 32'h5A5A0001; wstrb = 4'hF; wvalid = 1'b1;
    step(); wvalid = 1'b0;
    chk("lead_wready_low", wready, 1'b0);
    chk("lead_awready_high", awready, 1'b1);
    step(); step();
    chk("lead_w_held", {wready, bvalid}, 2'b00);
    awaddr = 5'h04; awvalid = 1'b1;
    step(); awvalid = 1'b0;
    chk("lead_awready_low", awready, 1'b0);
    chk("lead_no_early_b", bvalid, 1'b0);
    step();
    mdl[1] = 32'h5A5A0001;
    chk("lead_b", {bvalid, bresp}, 3'b100);
    chk("lead_regq", reg_q, mdl_flat());
    chk("lead_pulse", reg_wr_pulse, 4'b0010);
    awaddr = 5'h1C; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step(); awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_b", {bvalid, bresp}, 3'b100);
      chk("hold_ready", {awready, wready}, 2'b00);
      chk("hold_regq", reg_q, mdl_flat());
      chk("hold_pulse", reg_wr_pulse, 4'b0000);
      step();
    end
    bready = 1'b1;
    step();
    chk("coinc_b", {bvalid, bresp}, 3'b110);
    chk("coinc_regq", reg_q, mdl_flat());
    chk("coinc_pulse", reg_wr_pulse, 4'b0000);
    step();
    bready = 1'b0;
    chk("coinc_bdone", bvalid, 1'b0);
    chk("coinc_ready", {awready, wready}, 2'b11);

    // Out-of-range write and read
    snap = reg_q;
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, 1);
    chk("oor_regs_unchanged", reg_q, snap);
    axi_read(5'h14, 0);

    // Read held by RREADY while a same-edge write commits to the read address
    prev = mdl[1];
    awaddr = 5'h04; wdata = 32'h0BADCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step(); awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h04; arvalid = 1'b1;
    chk("col_arready", arready, 1'b1);
    step(); arvalid = 1'b0;
    chk("col_rvalid", {rvalid, bvalid}, 2'b11);
    chk("col_old_data", rdata, prev);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("col_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, prev});
    end
    bready = 1'b0;
    chk("col_bdone", bvalid, 1'b0);
    mdl[1] = 32'h0BADCAFE;
    chk("col_regq", reg_q, mdl_flat());
    rready = 1'b1;
    step(); rready = 1'b0;
    chk("col_rdone", {rvalid, arready}, 2'b01);
    axi_read(5'h04, 1);

    // Reset dropped with B pending and AW held in its slot
    awaddr = 5'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step(); awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("mid_pending", bvalid, 1'b1);
    awaddr = 5'h00; awvalid = 1'b1;
    step();
    #2 aresetn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    awvalid = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    chk("mid_ready", {awready, wready, arready}, 3'b111);
    axi_write(5'h08, 32'h12345678, 4'hF, 0);
    axi_read(5'h08, 0);

    // Randomized mix of writes and reads, some out of range, with response backpressure
    for (int it = 0; it < 60; it++) begin
      word = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = {word, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end
    for (int i = 0; i < NREG; i++) axi_read(5'(i * 4), 0);
    chk("final_regq", reg_q, mdl_flat());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
